// File: rtl/count_sequence_monitor.sv
// count_sequence_monitor
// Watches the output of the 0,1,2,4,5,6 JK counter. It checks that every
// enabled sample is the legal successor of the one before, decodes the code
// to a one-hot phase, counts completed laps (6->0), and freezes the first
// sequence error for inspection.
//
// Control priority at each rising Clock edge:
//   clear=0  >  err_clr=1  >  en=0  >  normal sampling
// Every output is registered and reflects the q sampled at the previous edge.
module count_sequence_monitor #(
  parameter int LAP_WIDTH = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic [2:0]           q,
  input  logic                 err_clr,
  output logic [5:0]           phase_onehot,
  output logic                 in_sync,
  output logic                 lap_pulse,
  output logic [LAP_WIDTH-1:0] lap_count,
  output logic                 lap_ovf,
  output logic                 error,
  output logic [2:0]           err_expected,
  output logic [2:0]           err_got
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t                 state_q;
  logic [2:0]             prev_q;
  logic [5:0]             phase_q;
  logic                   lap_pulse_q;
  logic [LAP_WIDTH-1:0]   lap_count_q;
  logic                   lap_ovf_q;
  logic                   error_q;
  logic [2:0]             err_exp_q;
  logic [2:0]             err_got_q;

  logic [2:0]             succ_d;
  logic [5:0]             phase_d;
  logic [LAP_WIDTH-1:0]   lap_count_d;
  logic                   q_illegal;
  logic                   lap_done;

  // Legal successor of a code; 3 and 7 never reach here as prev_q.
  function automatic logic [2:0] succ_of(input logic [2:0] v);
    logic [2:0] r;
    case (v)
      3'd0:    r = 3'd1;
      3'd1:    r = 3'd2;
      3'd2:    r = 3'd4;
      3'd4:    r = 3'd5;
      3'd5:    r = 3'd6;
      3'd6:    r = 3'd0;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // One-hot phase decode; illegal codes give all zeros.
  function automatic logic [5:0] decode(input logic [2:0] v);
    logic [5:0] r;
    case (v)
      3'd0:    r = 6'b000001;
      3'd1:    r = 6'b000010;
      3'd2:    r = 6'b000100;
      3'd4:    r = 6'b001000;
      3'd5:    r = 6'b010000;
      3'd6:    r = 6'b100000;
      default: r = 6'b000000;
    endcase
    return r;
  endfunction

  // Next-value helpers shared by the FSM below.
  always_comb begin
    succ_d      = succ_of(prev_q);
    phase_d     = decode(q);
    lap_count_d = lap_count_q + LAP_WIDTH'(1);
    q_illegal   = q[1] & q[0];
    lap_done    = (prev_q == 3'd6) && (q == 3'd0);
  end

  // Monitor FSM with all of its registered outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      prev_q      <= 3'd0;
      phase_q     <= 6'd0;
      lap_pulse_q <= 1'b0;
      lap_count_q <= '0;
      lap_ovf_q   <= 1'b0;
      error_q     <= 1'b0;
      err_exp_q   <= 3'd0;
      err_got_q   <= 3'd0;
    end else begin
      // The pulse only lives for the cycle after a lap completes.
      lap_pulse_q <= 1'b0;
      if (!clear) begin
        state_q     <= ST_IDLE;
        prev_q      <= 3'd0;
        phase_q     <= 6'd0;
        lap_count_q <= '0;
        lap_ovf_q   <= 1'b0;
        error_q     <= 1'b0;
        err_exp_q   <= 3'd0;
        err_got_q   <= 3'd0;
      end else if (err_clr) begin
        // Resync without losing the lap history.
        state_q   <= ST_IDLE;
        prev_q    <= 3'd0;
        error_q   <= 1'b0;
        err_exp_q <= 3'd0;
        err_got_q <= 3'd0;
      end else if (en) begin
        phase_q <= phase_d;
        case (state_q)
          ST_IDLE: begin
            if (q == 3'd0) begin
              state_q <= ST_TRACK;
              prev_q  <= 3'd0;
            end else if (q_illegal) begin
              state_q   <= ST_ERROR;
              error_q   <= 1'b1;
              err_exp_q <= 3'd0;
              err_got_q <= q;
            end
          end
          ST_TRACK: begin
            if (q == succ_d) begin
              prev_q <= q;
              if (lap_done) begin
                lap_count_q <= lap_count_d;
                lap_pulse_q <= 1'b1;
                if (&lap_count_q) begin
                  lap_ovf_q <= 1'b1;
                end
              end
            end else begin
              state_q   <= ST_ERROR;
              error_q   <= 1'b1;
              err_exp_q <= succ_d;
              err_got_q <= q;
            end
          end
          ST_ERROR: begin
            // Frozen until err_clr, clear or Reset.
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign phase_onehot = phase_q;
  assign in_sync      = (state_q == ST_TRACK);
  assign lap_pulse    = lap_pulse_q;
  assign lap_count    = lap_count_q;
  assign lap_ovf      = lap_ovf_q;
  assign error        = error_q;
  assign err_expected = err_exp_q;
  assign err_got      = err_got_q;

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Bench for count_sequence_monitor: directed scenarios with literal
// expectations, then randomized stimulus, all checked every cycle against a
// behavioural model. A second instance with LAP_WIDTH=2 exercises lap wrap.
module tb_count_sequence_monitor;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       clear = 1'b1;
  logic       en = 1'b0;
  logic [2:0] q = 3'd0;
  logic       err_clr = 1'b0;

  logic [5:0] phase_onehot;
  logic       in_sync, lap_pulse, lap_ovf, error;
  logic [7:0] lap_count;
  logic [2:0] err_expected, err_got;

  logic [5:0] phase2;
  logic       in_sync2, lap_pulse2, lap_ovf2, error2;
  logic [1:0] lap_count2;
  logic [2:0] err_expected2, err_got2;

  int n_tests = 0;
  int n_fail = 0;

  count_sequence_monitor #(.LAP_WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .clear(clear), .en(en), .q(q),
    .err_clr(err_clr), .phase_onehot(phase_onehot), .in_sync(in_sync),
    .lap_pulse(lap_pulse), .lap_count(lap_count), .lap_ovf(lap_ovf),
    .error(error), .err_expected(err_expected), .err_got(err_got)
  );

  count_sequence_monitor #(.LAP_WIDTH(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .clear(clear), .en(en), .q(q),
    .err_clr(err_clr), .phase_onehot(phase2), .in_sync(in_sync2),
    .lap_pulse(lap_pulse2), .lap_count(lap_count2), .lap_ovf(lap_ovf2),
    .error(error2), .err_expected(err_expected2), .err_got(err_got2)
  );

  // ---------------- clock ----------------
  always #5 Clock = ~Clock;

  // ---------------- checker ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int legal_seq[6] = '{0, 1, 2, 4, 5, 6};

  function automatic int idx_of(input logic [2:0] v);
    for (int i = 0; i < 6; i++) if (legal_seq[i] == int'(v)) return i;
    return -1;
  endfunction

  // m_pos: index in legal_seq of the last accepted code, -1 when not synced.
  int         m_pos = -1;
  bit         m_err = 0;
  int         m_phase = 0;
  bit         m_pulse = 0;
  int         m_lap8 = 0, m_lap2 = 0;
  bit         m_ovf8 = 0, m_ovf2 = 0;
  int         m_eexp = 0, m_egot = 0;
  logic [7:0] exp_q[$];

  always @(posedge Clock or negedge Reset) begin
    int ix, want;
    if (!Reset) begin
      m_pos = -1; m_err = 0; m_phase = 0; m_pulse = 0;
      m_lap8 = 0; m_lap2 = 0; m_ovf8 = 0; m_ovf2 = 0;
      m_eexp = 0; m_egot = 0;
      exp_q.delete();
    end else begin
      m_pulse = 0;
      if (!clear) begin
        m_pos = -1; m_err = 0; m_phase = 0;
        m_lap8 = 0; m_lap2 = 0; m_ovf8 = 0; m_ovf2 = 0;
        m_eexp = 0; m_egot = 0;
      end else if (err_clr) begin
        m_pos = -1; m_err = 0; m_eexp = 0; m_egot = 0;
      end else if (en) begin
        ix = idx_of(q);
        m_phase = (ix >= 0) ? (1 << ix) : 0;
        if (m_err) begin
          // frozen
        end else if (m_pos < 0) begin
          if (q == 3'd0) m_pos = 0;
          else if (ix < 0) begin
            m_err = 1; m_eexp = 0; m_egot = int'(q);
          end
        end else begin
          want = legal_seq[(m_pos + 1) % 6];
          if (int'(q) == want) begin
            if (m_pos == 5) begin
              m_pulse = 1;
              m_lap8 = (m_lap8 + 1) % 256;
              m_lap2 = (m_lap2 + 1) % 4;
              if (m_lap8 == 0) m_ovf8 = 1;
              if (m_lap2 == 0) m_ovf2 = 1;
              exp_q.push_back(8'(m_lap8));
            end
            m_pos = (m_pos + 1) % 6;
          end else begin
            m_err = 1; m_eexp = want; m_egot = int'(q); m_pos = -1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clock) begin
    if (Reset) begin
      chk("phase", int'(phase_onehot), m_phase);
      chk("in_sync", int'(in_sync), int'(m_pos >= 0 && !m_err));
      chk("lap_pulse", int'(lap_pulse), int'(m_pulse));
      chk("lap_count", int'(lap_count), m_lap8);
      chk("lap_ovf", int'(lap_ovf), int'(m_ovf8));
      chk("error", int'(error), int'(m_err));
      chk("err_expected", int'(err_expected), m_eexp);
      chk("err_got", int'(err_got), m_egot);
      chk("lap_count_w2", int'(lap_count2), m_lap2);
      chk("lap_ovf_w2", int'(lap_ovf2), int'(m_ovf2));
      chk("lap_pulse_w2", int'(lap_pulse2), int'(m_pulse));
      if (lap_pulse) begin
        if (exp_q.size() == 0) chk("lap_event_unexpected", 1, 0);
        else chk("lap_event_count", int'(lap_count), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit c, input bit ec, input bit e, input logic [2:0] qv);
    clear = c; err_clr = ec; en = e; q = qv;
    @(posedge Clock);
    #1;
  endtask

  task automatic run(input logic [2:0] qv);
    step(1'b1, 1'b0, 1'b1, qv);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"}, int'(phase_onehot), 0);
    chk({tag, "_in_sync"}, int'(in_sync), 0);
    chk({tag, "_lap_pulse"}, int'(lap_pulse), 0);
    chk({tag, "_lap_count"}, int'(lap_count), 0);
    chk({tag, "_lap_ovf"}, int'(lap_ovf), 0);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_err_expected"}, int'(err_expected), 0);
    chk({tag, "_err_got"}, int'(err_got), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] t1_q[8]  = '{0, 1, 2, 4, 5, 6, 0, 1};
    int         t1_ph[8] = '{1, 2, 4, 8, 16, 32, 1, 2};
    int         pos;
    bit         c, ec, e;
    logic [2:0] qv;

    #3;
    chk_all_zero("reset");
    #9 Reset = 1'b1;
    @(posedge Clock); #1;

    // Test 1: clean lap from reset.
    for (int i = 0; i < 8; i++) begin
      run(t1_q[i]);
      chk("t1_phase", int'(phase_onehot), t1_ph[i]);
      chk("t1_in_sync", int'(in_sync), 1);
      chk("t1_pulse", int'(lap_pulse), int'(i == 6));
      chk("t1_laps", int'(lap_count), (i >= 6) ? 1 : 0);
    end
    chk("t1_error", int'(error), 0);

    // Test 2: skip 2 after a 1 -> error, then frozen, then err_clr.
    run(2); run(4); run(5); run(6); run(0); run(1); run(4);
    chk("t2_error", int'(error), 1);
    chk("t2_exp", int'(err_expected), 2);
    chk("t2_got", int'(err_got), 4);
    chk("t2_in_sync", int'(in_sync), 0);
    run(5); run(6);
    chk("t2_exp_frozen", int'(err_expected), 2);
    chk("t2_got_frozen", int'(err_got), 4);
    chk("t2_laps_frozen", int'(lap_count), 2);
    step(1'b1, 1'b1, 1'b1, 3'd0);
    chk("t2_clr_error", int'(error), 0);
    chk("t2_clr_in_sync", int'(in_sync), 0);
    chk("t2_clr_laps", int'(lap_count), 2);

    // Test 3: IDLE behaviour.
    run(5);
    chk("t3_idle_err", int'(error), 0);
    chk("t3_idle_sync", int'(in_sync), 0);
    run(3);
    chk("t3_error", int'(error), 1);
    chk("t3_exp", int'(err_expected), 0);
    chk("t3_got", int'(err_got), 3);
    chk("t3_phase", int'(phase_onehot), 0);
    step(1'b1, 1'b1, 1'b1, 3'd0);

    // Test 4: en=0 hides a bogus q.
    run(0); run(1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 3'd5);
      chk("t4_hold_sync", int'(in_sync), 1);
      chk("t4_hold_phase", int'(phase_onehot), 2);
    end
    run(2);
    chk("t4_error", int'(error), 0);
    chk("t4_in_sync", int'(in_sync), 1);
    chk("t4_phase", int'(phase_onehot), 4);

    // Test 5: lap wrap on the 2-bit instance.
    step(1'b0, 1'b0, 1'b1, 3'd0);
    chk("t5_clr_laps_w2", int'(lap_count2), 0);
    run(0);
    for (int lap = 1; lap <= 4; lap++) begin
      run(1); run(2); run(4); run(5); run(6); run(0);
      chk("t5_laps_w2", int'(lap_count2), lap % 4);
      chk("t5_ovf_w2", int'(lap_ovf2), int'(lap == 4));
      chk("t5_laps_w8", int'(lap_count), lap);
    end
    step(1'b0, 1'b0, 1'b1, 3'd0);
    chk("t5_clear_laps_w2", int'(lap_count2), 0);
    chk("t5_clear_ovf_w2", int'(lap_ovf2), 0);

    // Test 6a: clear and err_clr together -> clear wins.
    run(0); run(1); run(2); run(4); run(5); run(6); run(0);
    chk("t6_laps_before", int'(lap_count), 1);
    step(1'b0, 1'b1, 1'b1, 3'd1);
    chk("t6_both_laps", int'(lap_count), 0);
    chk("t6_both_sync", int'(in_sync), 0);

    // Randomized phase: mostly a legal walk with glitches and control noise.
    pos = 0;
    repeat (2000) begin
      c  = ($urandom_range(0, 79) != 0);
      ec = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 11) == 0) qv = 3'($urandom_range(0, 7));
      else qv = 3'(legal_seq[pos]);
      step(c, ec, e, qv);
      if (e && c && !ec && qv == 3'(legal_seq[pos])) pos = (pos + 1) % 6;
    end

    // Test 6b: async reset between edges mid-TRACK.
    step(1'b0, 1'b0, 1'b1, 3'd0);
    run(0); run(1); run(2); run(4); run(5); run(6); run(0); run(1);
    chk("t6_laps_pre_reset", int'(lap_count), 1);
    #2 Reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    #3 Reset = 1'b1;
    @(posedge Clock); #1;
    run(0);
    chk("post_reset_sync", int'(in_sync), 1);

    chk("lap_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
